// File: rtl/mem_arbiter_if.sv
// Bundle for mem_arbiter: IFU and LSU request/response channels, memory port and status.
// master = the arbiter side; slave = requesters, memory and observers.
// Valid/ready on requests; responses are single-cycle pulses with no backpressure.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wen;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_req_ready;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_rdata;

  logic              m_req_valid;
  logic              m_req_ready;
  logic [ADDR_W-1:0] m_addr;
  logic              m_wen;
  logic [DATA_W-1:0] m_wdata;
  logic [MASK_W-1:0] m_wmask;
  logic              m_resp_valid;
  logic [DATA_W-1:0] m_rdata;

  logic              owner;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output m_req_valid, m_addr, m_wen, m_wdata, m_wmask,
    input  m_req_ready, m_resp_valid, m_rdata,
    output owner, busy, timeout_err
  );

  modport slave (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  m_req_valid, m_addr, m_wen, m_wdata, m_wmask,
    output m_req_ready, m_resp_valid, m_rdata,
    input  owner, busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight; ARB_RR_EN selects round-robin.
// Latency: accept cycle 0, m_req_valid cycle 1, response routed combinationally in WAIT_RESP (min 3-cycle turnaround).
// Backpressure: m_req_valid held through any m_req_ready=0 stall; no new accept while busy; WAIT_RESP times out.
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              grant_ls;
  logic              accept;
  logic              resp_hit;
  logic              timed_out;
  logic              done;

  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

`ifdef ARB_RR_EN
  logic last_ls;

  // On contention the side not served last wins; reset value (IFU-last) hands the first tie to LSU.
  always_comb grant_ls = bus.ls_req_valid && (!bus.if_req_valid || !last_ls);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_ls <= 1'b0;
    else if (accept) last_ls <= grant_ls;
  end
`else
  always_comb grant_ls = bus.ls_req_valid;
`endif

  always_comb begin
    accept    = (state == IDLE) && (bus.if_req_valid || bus.ls_req_valid);
    resp_hit  = (state == WAIT_RESP) && bus.m_resp_valid;
    timed_out = (state == WAIT_RESP) && !bus.m_resp_valid && (cnt == CNT_MAX);
    done      = resp_hit || timed_out;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = REQ;
      REQ:       if (bus.m_req_ready) state_nxt = WAIT_RESP;
      WAIT_RESP: if (done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt <= '0;
    else if (state == REQ && bus.m_req_ready)  cnt <= '0;
    else if (state == WAIT_RESP && !done)      cnt <= cnt + CNT_W'(1);
  end

  // IFU is read-only, so its wen/mask/wdata are forced to zero at capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      owner_q <= grant_ls;
      addr_q  <= grant_ls ? bus.ls_addr : bus.if_addr;
      wen_q   <= grant_ls && bus.ls_wen;
      wdata_q <= grant_ls ? bus.ls_wdata : '0;
      wmask_q <= (grant_ls && bus.ls_wen) ? bus.ls_wmask : '0;
    end
  end

  always_comb begin
    bus.if_req_ready  = (state == IDLE) && bus.if_req_valid && !grant_ls;
    bus.ls_req_ready  = (state == IDLE) && grant_ls;

    bus.if_resp_valid = done && !owner_q;
    bus.ls_resp_valid = done && owner_q;
    bus.if_rdata      = (resp_hit && !owner_q) ? bus.m_rdata : '0;
    bus.ls_rdata      = (resp_hit && owner_q)  ? bus.m_rdata : '0;

    bus.m_req_valid   = (state == REQ);
    bus.m_addr        = addr_q;
    bus.m_wen         = wen_q;
    bus.m_wdata       = wdata_q;
    bus.m_wmask       = wmask_q;

    bus.owner         = owner_q;
    bus.busy          = (state != IDLE);
    bus.timeout_err   = timed_out;
  end
endmodule
